// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Purpose
//   Shares one single-ported unified memory (1024 x 32 by default) between the
//   instruction-fetch requester (IF, read-only) and the data requester
//   (DM, loads and stores from the MEM stage). Only one access is in flight at
//   a time. DM normally wins a simultaneous request. After MAX_DATA_RUN
//   consecutive DM grants made while IF was waiting, IF gets the next grant.
//
//   Sequence per access: IDLE -> ISSUE (1 cycle, mem_en) -> WAIT (MEM_LAT
//   cycles) -> DONE (1 cycle, done pulse) -> IDLE.
//   A request sampled in cycle 0 completes in cycle 2+MEM_LAT.
//
// Parameters
//   ADDR_W        word-address width
//   DATA_W        data width
//   MEM_LAT       memory read latency, mem_en cycle -> mem_rdata valid (1..7)
//   MAX_DATA_RUN  max consecutive DM grants while IF is pending
//
// Ports
//   i_clk1        clock, rising edge
//   i_rst         asynchronous reset, active high
//   i_if_req      fetch request (held with i_if_addr until o_if_done)
//   i_if_addr     fetch word address
//   o_if_done     one-cycle pulse, fetch complete
//   o_if_rdata    fetched word, held until the next fetch completion
//   i_dm_req      data request (fields held until o_dm_done)
//   i_dm_we       1 = store, 0 = load
//   i_dm_addr     data word address
//   i_dm_wdata    store data
//   o_dm_done     one-cycle pulse, data access complete
//   o_dm_rdata    load data, held until the next DM load completion
//   o_mem_en      memory enable, one cycle per access
//   o_mem_we      memory write enable, valid with o_mem_en
//   o_mem_addr    memory address, valid with o_mem_en
//   o_mem_wdata   memory write data, valid with o_mem_en
//   i_mem_rdata   memory read data, valid MEM_LAT cycles after o_mem_en
//   o_busy        high whenever the FSM is not IDLE
//
// Optional feature (macro ARB_PERF_CNT_EN)
//   When defined, adds o_conflict_cnt[15:0] (grants made with both requests
//   high) and o_starve_cnt[15:0] (IF grants forced by the DM run limit).
//   Both saturate at 16'hFFFF. Arbitration is identical either way.
//
// All outputs are registered. The FSM and every output live in one always_ff.
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              i_clk1,
    input  logic              i_rst,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]       o_conflict_cnt,
    output logic [15:0]       o_starve_cnt,
`endif
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_done,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int               RUN_W     = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_DATA_RUN);
    // WAIT counter runs 0 .. MEM_LAT-1; three bits cover the legal 1..7 range.
    localparam logic [2:0]       WAIT_LAST = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic             r_owner_dm;   // 0 = IF owns the access, 1 = DM
    logic             r_we;         // latched store flag of the access in flight
    logic [RUN_W-1:0] r_data_run;   // consecutive DM grants made while IF waited
    logic [2:0]       r_wait_cnt;

    // ------------------------------------------------------------------------
    // Grant decision (only consumed in IDLE)
    // ------------------------------------------------------------------------
    logic w_any_req;
    logic w_both_req;
    logic w_run_full;
    logic w_grant_dm;
    logic w_forced_if;

    assign w_any_req   = i_if_req | i_dm_req;
    assign w_both_req  = i_if_req & i_dm_req;
    assign w_run_full  = (r_data_run == RUN_MAX);
    // DM wins unless IF is waiting and DM has already used up its run.
    assign w_grant_dm  = i_dm_req & ~(i_if_req & w_run_full);
    assign w_forced_if = w_both_req & w_run_full;

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk1 or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_owner_dm  <= 1'b0;
            r_we        <= 1'b0;
            r_data_run  <= '0;
            r_wait_cnt  <= '0;
            o_if_done   <= 1'b0;
            o_if_rdata  <= '0;
            o_dm_done   <= 1'b0;
            o_dm_rdata  <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_busy      <= 1'b0;
`ifdef ARB_PERF_CNT_EN
            o_conflict_cnt <= '0;
            o_starve_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Latch the winner's fields straight into the memory
                        // output registers; they drive the ISSUE cycle.
                        r_owner_dm  <= w_grant_dm;
                        r_we        <= w_grant_dm & i_dm_we;
                        o_mem_en    <= 1'b1;
                        o_mem_we    <= w_grant_dm & i_dm_we;
                        o_mem_addr  <= w_grant_dm ? i_dm_addr : i_if_addr;
                        o_mem_wdata <= w_grant_dm ? i_dm_wdata : '0;
                        o_busy      <= 1'b1;
                        r_state     <= S_ISSUE;

                        // The run only grows while IF is actually waiting;
                        // an uncontested DM grant or any IF grant restarts it.
                        if (w_grant_dm && i_if_req) begin
                            if (!w_run_full) begin
                                r_data_run <= r_data_run + 1'b1;
                            end
                        end else begin
                            r_data_run <= '0;
                        end

`ifdef ARB_PERF_CNT_EN
                        if (w_both_req && (o_conflict_cnt != 16'hFFFF)) begin
                            o_conflict_cnt <= o_conflict_cnt + 16'd1;
                        end
                        if (w_forced_if && (o_starve_cnt != 16'hFFFF)) begin
                            o_starve_cnt <= o_starve_cnt + 16'd1;
                        end
`endif
                    end
                end

                S_ISSUE: begin
                    // The memory sees enable (and any write) for exactly one cycle.
                    o_mem_en   <= 1'b0;
                    o_mem_we   <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        // Read data is valid in this last WAIT cycle; capture it
                        // for the owner and raise its done pulse for DONE.
                        if (r_owner_dm) begin
                            if (!r_we) begin
                                o_dm_rdata <= i_mem_rdata;
                            end
                            o_dm_done <= 1'b1;
                        end else begin
                            o_if_rdata <= i_mem_rdata;
                            o_if_done  <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end

                S_DONE: begin
                    o_if_done <= 1'b0;
                    o_dm_done <= 1'b0;
                    o_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // w_forced_if only feeds the optional counters.
    logic w_unused;
    assign w_unused = w_forced_if;

endmodule
